// File: rtl/coef_loader.sv
// -----------------------------------------------------------------------------
// coef_loader : streams masked 20-bit coefficients to an SPI slave, one frame per index.
// Optional abort port pair enabled by defining COEF_LOADER_ABORT_EN.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module coef_loader #(
   parameter int GAP_CYCLES = 2
) (
   input  logic        SCLK,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  mask,
   input  logic [19:0] coef_data,
`ifdef COEF_LOADER_ABORT_EN
   input  logic        abort,
   output logic        aborted,
`endif
   output logic [2:0]  coef_addr,
   output logic        mosi,
   output logic        ss_n,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      LOAD   = 3'd2,
      SHIFT  = 3'd3,
      GAP    = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t      state, nxt_state;
   logic [7:0]  mask_q, nxt_mask_q;
   logic [3:0]  search_idx, nxt_search_idx;
   logic [4:0]  bit_cnt, nxt_bit_cnt;
   logic [3:0]  gap_cnt, nxt_gap_cnt;
   logic [30:0] shreg, nxt_shreg;
   logic [2:0]  nxt_coef_addr;
   logic        nxt_mosi, nxt_ss_n, nxt_busy, nxt_done, nxt_aborted;
   logic        found;
   logic [2:0]  found_idx;
   logic [31:0] frame;

   // Search index is 4 bits wide so that "past index 7" is representable and ends the scan
   always_comb begin
      found     = 1'b0;
      found_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask_q[i] && (4'(i) >= search_idx)) begin
            found     = 1'b1;
            found_idx = 3'(i);
         end
      end
   end

   assign frame = {1'b1, 3'b000, {1'b0, coef_addr} + 4'd1, coef_data, 4'b0000};

   always_comb begin
      nxt_state      = state;
      nxt_mask_q     = mask_q;
      nxt_search_idx = search_idx;
      nxt_bit_cnt    = bit_cnt;
      nxt_gap_cnt    = gap_cnt;
      nxt_shreg      = shreg;
      nxt_coef_addr  = coef_addr;
      nxt_mosi       = mosi;
      nxt_ss_n       = ss_n;
      nxt_busy       = busy;
      nxt_done       = 1'b0;
      nxt_aborted    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nxt_mask_q     = mask;
               nxt_busy       = 1'b1;
               nxt_search_idx = 4'd0;
               nxt_state      = SELECT;
            end
         end
         SELECT: begin
            if (found) begin
               nxt_coef_addr = found_idx;
               nxt_state     = LOAD;
            end else begin
               nxt_state = DONE;
            end
         end
         LOAD: begin
            nxt_shreg   = frame[30:0];
            nxt_mosi    = frame[31];
            nxt_ss_n    = 1'b0;
            nxt_bit_cnt = 5'd0;
            nxt_state   = SHIFT;
         end
         SHIFT: begin
            if (bit_cnt != 5'd31) begin
               nxt_mosi    = shreg[30];
               nxt_shreg   = {shreg[29:0], 1'b0};
               nxt_bit_cnt = bit_cnt + 5'd1;
            end else begin
               nxt_ss_n    = 1'b1;
               nxt_mosi    = 1'b0;
               nxt_gap_cnt = 4'd0;
               nxt_state   = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
               nxt_search_idx = {1'b0, coef_addr} + 4'd1;
               nxt_state      = SELECT;
            end else begin
               nxt_gap_cnt = gap_cnt + 4'd1;
            end
         end
         DONE: begin
            nxt_done  = 1'b1;
            nxt_busy  = 1'b0;
            nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
`ifdef COEF_LOADER_ABORT_EN
      if (abort && (state != IDLE)) begin
         nxt_state   = IDLE;
         nxt_ss_n    = 1'b1;
         nxt_mosi    = 1'b0;
         nxt_busy    = 1'b0;
         nxt_done    = 1'b0;
         nxt_aborted = 1'b1;
      end
`endif
   end

   // Falling-edge updates keep outputs stable for the slave's rising-edge sample
   always_ff @(negedge SCLK or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         mask_q     <= 8'd0;
         search_idx <= 4'd0;
         bit_cnt    <= 5'd0;
         gap_cnt    <= 4'd0;
         shreg      <= 31'd0;
         coef_addr  <= 3'd0;
         mosi       <= 1'b0;
         ss_n       <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= nxt_state;
         mask_q     <= nxt_mask_q;
         search_idx <= nxt_search_idx;
         bit_cnt    <= nxt_bit_cnt;
         gap_cnt    <= nxt_gap_cnt;
         shreg      <= nxt_shreg;
         coef_addr  <= nxt_coef_addr;
         mosi       <= nxt_mosi;
         ss_n       <= nxt_ss_n;
         busy       <= nxt_busy;
         done       <= nxt_done;
      end
   end

`ifdef COEF_LOADER_ABORT_EN
   always_ff @(negedge SCLK or posedge reset) begin
      if (reset) aborted <= 1'b0;
      else       aborted <= nxt_aborted;
   end
`else
   logic unused_aborted;
   assign unused_aborted = nxt_aborted;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coef_loader.sv
// Directed bench for coef_loader: table-driven bank loads plus reset/re-start/abort sequences.
`default_nettype none

module tb_coef_loader;

   logic        SCLK = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  mask = 8'd0;
   logic [19:0] coef_data;
   logic [2:0]  coef_addr;
   logic        mosi, ss_n, busy, done;
`ifdef COEF_LOADER_ABORT_EN
   logic        abort = 1'b0;
   logic        aborted;
`endif

   logic [19:0] rom [8];
   assign coef_data = rom[coef_addr];

   coef_loader #(.GAP_CYCLES(2)) dut (
      .SCLK(SCLK), .reset(reset), .start(start), .mask(mask), .coef_data(coef_data),
`ifdef COEF_LOADER_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .coef_addr(coef_addr), .mosi(mosi), .ss_n(ss_n), .busy(busy), .done(done)
   );

   always #5 SCLK = ~SCLK;

   int total = 0;
   int bad = 0;
   int low, done_pulses, bad_low, done_edge;
   logic [31:0] sh;
   logic [2:0]  cur_addr;
   logic [31:0] frames[$];
   logic [2:0]  addrs[$];

   typedef struct {
      logic [7:0]  m;
      int          nf;
      int          de;
      logic [31:0] f0;
      logic [31:0] fl;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge SCLK);
      #1;
   endtask

   task automatic clear_obs();
      frames.delete();
      addrs.delete();
      low = 0; sh = 0; done_pulses = 0; bad_low = 0; done_edge = -1;
   endtask

   task automatic observe();
      if (!ss_n) begin
         sh = {sh[30:0], mosi};
         low++;
         cur_addr = coef_addr;
      end else if (low > 0) begin
         frames.push_back(sh);
         addrs.push_back(cur_addr);
         if (low != 32) bad_low++;
         low = 0;
      end
      if (done) done_pulses++;
   endtask

   task automatic run_load(input logic [7:0] m, input bit repulse);
      clear_obs();
      mask = m; start = 1'b1;
      step();
      start = 1'b0;
      mask = ~m;
      chk("busy_after_accept", busy, 1);
      for (int e = 1; e <= 600 && done_edge < 0; e++) begin
         start = (repulse && frames.size() == 1 && low == 5);
         step();
         observe();
         if (done) done_edge = e;
      end
      start = 1'b0;
      for (int e = 0; e < 4; e++) begin
         step();
         observe();
      end
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      logic [7:0] exp_ab [4];
      logic [2:0] exp_ad [4];
      int viol;
      int ab_pulses;
      rom[0] = 20'hABCDE; rom[1] = 20'h11111; rom[2] = 20'h22222; rom[3] = 20'h33333;
      rom[4] = 20'h44444; rom[5] = 20'h55555; rom[6] = 20'h66666; rom[7] = 20'h77777;

      vecs[0] = '{8'h00, 0,   2, 32'h0,        32'h0};
      vecs[1] = '{8'h01, 1,  38, 32'h81ABCDE0, 32'h81ABCDE0};
      vecs[2] = '{8'hA5, 4, 146, 32'h81ABCDE0, 32'h88777770};
      vecs[3] = '{8'h80, 1,  38, 32'h88777770, 32'h88777770};
      vecs[4] = '{8'h24, 2,  74, 32'h83222220, 32'h86555550};
      exp_ab = '{8'h81, 8'h83, 8'h86, 8'h88};
      exp_ad = '{3'd0, 3'd2, 3'd5, 3'd7};

      #12;
      chk("rst_ss_n", ss_n, 1);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", coef_addr, 0);
      step();
      reset = 1'b0;
      step();

      foreach (vecs[i]) begin
         run_load(vecs[i].m, 1'b0);
         chk($sformatf("v%0d_nframes", i), frames.size(), vecs[i].nf);
         chk($sformatf("v%0d_done_edge", i), done_edge, vecs[i].de);
         chk($sformatf("v%0d_done_pulses", i), done_pulses, 1);
         chk($sformatf("v%0d_ss_low_len", i), bad_low, 0);
         chk($sformatf("v%0d_first_frame", i), frames.size() > 0 ? frames[0] : 32'h0, vecs[i].f0);
         chk($sformatf("v%0d_last_frame", i), frames.size() > 0 ? frames[frames.size()-1] : 32'h0, vecs[i].fl);
      end

      // address bytes and index order for a sparse mask
      run_load(8'hA5, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("a5_addr_byte%0d", k), frames.size() > k ? {24'h0, frames[k][31:24]} : 32'h0, {24'h0, exp_ab[k]});
         chk($sformatf("a5_coef_addr%0d", k), addrs.size() > k ? {29'h0, addrs[k]} : 32'hFFFF, {29'h0, exp_ad[k]});
      end

      // start pulsed again mid-load is ignored
      run_load(8'hFF, 1'b1);
      chk("repulse_nframes", frames.size(), 8);
      chk("repulse_done_edge", done_edge, 290);
      chk("repulse_done_pulses", done_pulses, 1);
      chk("repulse_ss_low_len", bad_low, 0);

      // asynchronous reset in the middle of a frame
      clear_obs();
      mask = 8'h01; start = 1'b1;
      step();
      start = 1'b0;
      for (int e = 0; e < 80; e++) begin
         if (low == 12) break;
         step();
         observe();
      end
      chk("rst_mid_reached", low, 12);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_ss_n", ss_n, 1);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_addr", coef_addr, 0);
      chk("rst_mid_mosi", mosi, 0);
      step();
      step();
      reset = 1'b0;
      viol = 0;
      for (int e = 0; e < 50; e++) begin
         step();
         if (!ss_n || busy || done) viol++;
      end
      chk("rst_then_idle", viol, 0);
      run_load(8'h01, 1'b0);
      chk("rst_reload_done_edge", done_edge, 38);
      chk("rst_reload_frame", frames.size() > 0 ? frames[0] : 32'h0, 32'h81ABCDE0);

`ifdef COEF_LOADER_ABORT_EN
      abort = 1'b1;
      step();
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_aborted", aborted, 0);
      mask = 8'h01; start = 1'b1;
      step();
      start = 1'b0;
      chk("abort_start_wins_busy", busy, 1);
      chk("abort_start_wins_aborted", aborted, 0);
      step();
      abort = 1'b0;
      chk("abort_select_busy", busy, 0);
      chk("abort_select_aborted", aborted, 1);
      step();

      clear_obs();
      mask = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      for (int e = 0; e < 200; e++) begin
         if (frames.size() == 2 && low == 5) break;
         step();
         observe();
      end
      chk("abort_reached", low, 5);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_ss_n", ss_n, 1);
      chk("abort_mosi", mosi, 0);
      chk("abort_busy", busy, 0);
      chk("abort_pulse", aborted, 1);
      ab_pulses = 1;
      viol = 0;
      for (int e = 0; e < 60; e++) begin
         step();
         if (aborted) ab_pulses++;
         if (done) done_pulses++;
         if (!ss_n || busy) viol++;
      end
      chk("abort_pulse_count", ab_pulses, 1);
      chk("abort_no_done", done_pulses, 0);
      chk("abort_stays_idle", viol, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
